// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator.
// Accepts one read or write command from a local requester, runs the matching
// AXI-Lite transaction and presents the data and response until they are consumed.
// Optional build macro: AXI_MASTER_ALIGN_CHECK_EN rejects misaligned commands
// locally with SLVERR and issues no AXI traffic for them.
module axi_lite_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    // local command channel
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_we,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
    // local response channel
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]              o_rsp_resp,
    // AXI write address
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    // AXI write response
    output logic                    o_bready,
    input  logic                    i_bvalid,
    input  logic [1:0]              i_bresp,
    // AXI read address
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    // AXI read data
    output logic                    o_rready,
    input  logic                    i_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    accept;
    logic                    aw_pending;
    logic                    w_pending;

    logic                    cmd_ready_nxt;
    logic                    rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
    logic [1:0]              rsp_resp_nxt;
    logic [ADDR_WIDTH-1:0]   awaddr_nxt;
    logic                    awvalid_nxt;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic [STRB_WIDTH-1:0]   wstrb_nxt;
    logic                    wvalid_nxt;
    logic                    bready_nxt;
    logic [ADDR_WIDTH-1:0]   araddr_nxt;
    logic                    arvalid_nxt;
    logic                    rready_nxt;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
    logic                    misaligned;
    assign misaligned = (i_cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
`endif

    // A command is taken only while idle and advertising ready.
    assign accept     = (state == IDLE) && o_cmd_ready && i_cmd_valid;
    // An AXI write channel stays pending until its own handshake completes.
    assign aw_pending = o_awvalid && !i_awready;
    assign w_pending  = o_wvalid  && !i_wready;

    // Next-state and next-output decode; every output is then registered.
    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = o_rsp_valid;
        rsp_rdata_nxt = o_rsp_rdata;
        rsp_resp_nxt  = o_rsp_resp;
        awaddr_nxt    = o_awaddr;
        awvalid_nxt   = o_awvalid;
        wdata_nxt     = o_wdata;
        wstrb_nxt     = o_wstrb;
        wvalid_nxt    = o_wvalid;
        bready_nxt    = o_bready;
        araddr_nxt    = o_araddr;
        arvalid_nxt   = o_arvalid;
        rready_nxt    = o_rready;

        case (state)
            IDLE: begin
                if (accept) begin
`ifdef AXI_MASTER_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = '0;
                        rsp_resp_nxt  = 2'b10;
                    end else
`endif
                    if (i_cmd_we) begin
                        state_nxt   = WRITE;
                        awaddr_nxt  = i_cmd_addr;
                        wdata_nxt   = i_cmd_wdata;
                        wstrb_nxt   = i_cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = READ;
                        araddr_nxt  = i_cmd_addr;
                        arvalid_nxt = 1'b1;
                    end
                end
            end

            WRITE: begin
                // AW and W retire independently; move on once neither is pending.
                awvalid_nxt = aw_pending;
                wvalid_nxt  = w_pending;
                if (!aw_pending && !w_pending) begin
                    state_nxt  = WAIT_B;
                    bready_nxt = 1'b1;
                end
            end

            WAIT_B: begin
                if (i_bvalid) begin
                    state_nxt     = RESP;
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = i_bresp;
                end
            end

            READ: begin
                if (i_arready) begin
                    state_nxt   = WAIT_R;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                end
            end

            WAIT_R: begin
                if (i_rvalid) begin
                    state_nxt     = RESP;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = i_rdata;
                    rsp_resp_nxt  = i_rresp;
                end
            end

            RESP: begin
                if (i_rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Registered ready is derived from the upcoming state so it is high exactly in IDLE.
        cmd_ready_nxt = (state_nxt == IDLE);
    end

    // State and output registers with synchronous reset that aborts any transaction.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state       <= IDLE;
            o_cmd_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= '0;
            o_awaddr    <= '0;
            o_awvalid   <= 1'b0;
            o_wdata     <= '0;
            o_wstrb     <= '0;
            o_wvalid    <= 1'b0;
            o_bready    <= 1'b0;
            o_araddr    <= '0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_cmd_ready <= cmd_ready_nxt;
            o_rsp_valid <= rsp_valid_nxt;
            o_rsp_rdata <= rsp_rdata_nxt;
            o_rsp_resp  <= rsp_resp_nxt;
            o_awaddr    <= awaddr_nxt;
            o_awvalid   <= awvalid_nxt;
            o_wdata     <= wdata_nxt;
            o_wstrb     <= wstrb_nxt;
            o_wvalid    <= wvalid_nxt;
            o_bready    <= bready_nxt;
            o_araddr    <= araddr_nxt;
            o_arvalid   <= arvalid_nxt;
            o_rready    <= rready_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed, table-driven bench for axi_lite_master.
// Each vector describes one command, the slave's ready/response timing and the
// expected response, latency and per-channel valid durations.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_areset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [31:0] o_awaddr;
    logic        o_awvalid;
    logic        i_awready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_wvalid;
    logic        i_wready;
    logic        o_bready;
    logic        i_bvalid;
    logic [1:0]  i_bresp;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic        o_rready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;

    axi_lite_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .i_aclk      (clk),
        .i_areset    (i_areset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_we    (i_cmd_we),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .i_cmd_wstrb (i_cmd_wstrb),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_resp  (o_rsp_resp),
        .o_awaddr    (o_awaddr),
        .o_awvalid   (o_awvalid),
        .i_awready   (i_awready),
        .o_wdata     (o_wdata),
        .o_wstrb     (o_wstrb),
        .o_wvalid    (o_wvalid),
        .i_wready    (i_wready),
        .o_bready    (o_bready),
        .i_bvalid    (i_bvalid),
        .i_bresp     (i_bresp),
        .o_araddr    (o_araddr),
        .o_arvalid   (o_arvalid),
        .i_arready   (i_arready),
        .o_rready    (o_rready),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .i_rresp     (i_rresp)
    );

    typedef struct {
        string       name;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_at;     // valid cycle (1-based) in which awready rises
        int          w_at;
        int          ar_at;
        int          rb_at;     // cycle after address/data handshake in which B/R valid rises
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        int          hold;      // cycles rsp_ready is held low
        int          exp_lat;   // clock edges from accept to rsp_valid
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_aw;    // cycles o_awvalid is high
        int          exp_w;
        int          exp_ar;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit outs_zero();
        return !(o_cmd_ready | o_rsp_valid | (|o_rsp_rdata) | (|o_rsp_resp) |
                 (|o_awaddr) | o_awvalid | (|o_wdata) | (|o_wstrb) | o_wvalid |
                 o_bready | (|o_araddr) | o_arvalid | o_rready);
    endfunction

    task automatic slave_idle();
        i_awready = 1'b0;
        i_wready  = 1'b0;
        i_arready = 1'b0;
        i_bvalid  = 1'b0;
        i_rvalid  = 1'b0;
    endtask

    task automatic wait_cmd_ready(input string name);
        int n = 0;
        while (!o_cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check({name, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   aw_n = 0, w_n = 0, ar_n = 0, b_cnt = 0, r_cnt = 0;
        bit   aw_done = 0, w_done = 0, ar_done = 0;
        bit   b_pend = 0, r_pend = 0, b_started = 0, r_started = 0;
        bit   hs_b, hs_r;
        bit   p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
        bit   chan_ok = 1, stable_ok = 1;
        logic [31:0] cap_rdata;
        logic [1:0]  cap_resp;

        wait_cmd_ready(v.name);
        i_cmd_we    = v.we;
        i_cmd_addr  = v.addr;
        i_cmd_wdata = v.wdata;
        i_cmd_wstrb = v.wstrb;
        i_cmd_valid = 1'b1;
        tick();
        // Scramble the command bus so any late capture shows up on the AXI side.
        i_cmd_valid = 1'b0;
        i_cmd_addr  = '1;
        i_cmd_wdata = '1;
        i_cmd_wstrb = '1;

        cyc = 1;
        while (!o_rsp_valid && cyc <= 50) begin
            if (p_awv && !p_awr && !o_awvalid) chan_ok = 0;
            if (p_wv  && !p_wr  && !o_wvalid)  chan_ok = 0;
            if (p_arv && !p_arr && !o_arvalid) chan_ok = 0;
            if (cyc == 1 && (o_awvalid != v.we || o_wvalid != v.we || o_arvalid != !v.we))
                chan_ok = 0;
            if (o_cmd_ready) chan_ok = 0;

            i_awready = o_awvalid && (aw_n + 1 >= v.aw_at);
            i_wready  = o_wvalid  && (w_n + 1 >= v.w_at);
            i_arready = o_arvalid && (ar_n + 1 >= v.ar_at);
            i_bvalid  = b_pend && (b_cnt + 1 >= v.rb_at);
            i_bresp   = v.slv_resp;
            i_rvalid  = r_pend && (r_cnt + 1 >= v.rb_at);
            i_rresp   = v.slv_resp;
            i_rdata   = v.slv_rdata;

            if (o_awvalid) begin
                aw_n++;
                if (o_awaddr !== v.addr) chan_ok = 0;
            end
            if (o_wvalid) begin
                w_n++;
                if (o_wdata !== v.wdata || o_wstrb !== v.wstrb) chan_ok = 0;
            end
            if (o_arvalid) begin
                ar_n++;
                if (o_araddr !== v.addr) chan_ok = 0;
            end

            hs_b = i_bvalid && o_bready;
            hs_r = i_rvalid && o_rready;
            if (i_awready) aw_done = 1;
            if (i_wready)  w_done  = 1;
            if (i_arready) ar_done = 1;
            p_awv = o_awvalid; p_awr = i_awready;
            p_wv  = o_wvalid;  p_wr  = i_wready;
            p_arv = o_arvalid; p_arr = i_arready;

            if (b_pend) b_cnt++;
            if (hs_b) b_pend = 0;
            if (aw_done && w_done && !b_started) begin
                b_pend = 1;
                b_started = 1;
            end
            if (r_pend) r_cnt++;
            if (hs_r) r_pend = 0;
            if (ar_done && !r_started) begin
                r_pend = 1;
                r_started = 1;
            end

            tick();
            cyc++;
        end
        slave_idle();

        check({v.name, "_latency"}, 64'(cyc), 64'(v.exp_lat));
        check({v.name, "_aw_cycles"}, 64'(aw_n), 64'(v.exp_aw));
        check({v.name, "_w_cycles"}, 64'(w_n), 64'(v.exp_w));
        check({v.name, "_ar_cycles"}, 64'(ar_n), 64'(v.exp_ar));
        check({v.name, "_channel_ok"}, 64'(chan_ok), 64'd1);
        check({v.name, "_rdata"}, 64'(o_rsp_rdata), 64'(v.exp_rdata));
        check({v.name, "_resp"}, 64'(o_rsp_resp), 64'(v.exp_resp));

        cap_rdata = o_rsp_rdata;
        cap_resp  = o_rsp_resp;
        for (int k = 0; k < v.hold; k++) begin
            if (!o_rsp_valid || o_rsp_rdata !== cap_rdata || o_rsp_resp !== cap_resp || o_cmd_ready)
                stable_ok = 0;
            tick();
        end
        if (!o_rsp_valid || o_rsp_rdata !== cap_rdata || o_rsp_resp !== cap_resp || o_cmd_ready)
            stable_ok = 0;
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check({v.name, "_rsp_stable"}, 64'(stable_ok), 64'd1);
        check({v.name, "_after_rsp_hs"}, 64'({o_rsp_valid, o_cmd_ready}), 64'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = '{"wr_zero_wait", 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 1, 1, 1, 1,
                    2'b00, 32'h5555_AAAA, 0, 3, 32'h0, 2'b00, 1, 1, 0};
        vecs[1] = '{"rd_ar_delay", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1, 1, 3, 1,
                    2'b00, 32'hCAFE_BABE, 0, 5, 32'hCAFE_BABE, 2'b00, 0, 0, 3};
        vecs[2] = '{"wr_aw_first", 1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 1, 3, 1, 1,
                    2'b00, 32'h5555_AAAA, 5, 5, 32'h0, 2'b00, 1, 3, 0};
        vecs[3] = '{"wr_w_first", 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hC, 3, 1, 1, 2,
                    2'b11, 32'h5555_AAAA, 5, 6, 32'h0, 2'b11, 3, 1, 0};
        vecs[4] = '{"rd_slverr", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1, 1, 1, 3,
                    2'b10, 32'h0BAD_F00D, 1, 5, 32'h0BAD_F00D, 2'b10, 0, 0, 1};
        vecs[5] = '{"wr_both_wait", 1'b1, 32'h0000_003C, 32'h8765_4321, 4'h5, 2, 2, 1, 1,
                    2'b10, 32'hFFFF_FFFF, 2, 4, 32'h0, 2'b10, 2, 2, 0};
`ifdef AXI_MASTER_ALIGN_CHECK_EN
        vecs[6] = '{"rd_misaligned", 1'b0, 32'h0000_0002, 32'h0, 4'h0, 1, 1, 1, 1,
                    2'b00, 32'h1122_3344, 0, 1, 32'h0, 2'b10, 0, 0, 0};
`else
        vecs[6] = '{"rd_misaligned", 1'b0, 32'h0000_0002, 32'h0, 4'h0, 1, 1, 1, 1,
                    2'b00, 32'h1122_3344, 0, 3, 32'h1122_3344, 2'b00, 0, 0, 1};
`endif

        i_areset    = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        i_cmd_wstrb = '0;
        i_rsp_ready = 1'b0;
        i_bresp     = '0;
        i_rdata     = '0;
        i_rresp     = '0;
        slave_idle();

        // Power-on reset: everything low, ready one cycle after release.
        tick();
        tick();
        tick();
        check("reset_outputs_zero", 64'(outs_zero()), 64'd1);
        i_areset = 1'b0;
        tick();
        check("cmd_ready_after_reset", 64'(o_cmd_ready), 64'd1);

        // Stray B/R valids while idle must be ignored.
        i_bvalid = 1'b1;
        i_rvalid = 1'b1;
        i_rdata  = 32'h7777_7777;
        tick();
        tick();
        slave_idle();
        check("idle_ignores_b_r", 64'({o_rsp_valid, o_cmd_ready, o_bready, o_rready}), 64'b0100);

        // Read that stalls in WAIT_R, then reset aborts it.
        i_cmd_we    = 1'b0;
        i_cmd_addr  = 32'h0000_0040;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        n = 0;
        while (!o_rready && n < 20) begin
            i_arready = o_arvalid;
            tick();
            n++;
        end
        i_arready = 1'b0;
        check("reached_wait_r", 64'(o_rready), 64'd1);
        i_areset = 1'b1;
        tick();
        check("reset_in_wait_r_zero", 64'(outs_zero()), 64'd1);
        i_areset = 1'b0;
        i_rvalid = 1'b1;
        i_rdata  = 32'h9999_9999;
        tick();
        check("post_reset_idle", 64'({o_cmd_ready, o_rsp_valid, o_rready}), 64'b100);
        tick();
        slave_idle();
        check("post_reset_r_ignored", 64'({o_cmd_ready, o_rsp_valid}), 64'b10);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
